// File: rtl/mbinit_param_module_side_pkg.sv
// Shared MBINIT definitions: sideband message codes, data-field layout and
// the PARAM-stage state encoding.
package mbinit_param_module_side_pkg;

  localparam int RATE_W     = 4;
  localparam int VSWING_W   = 5;
  localparam int FIELD_W    = 16;
  localparam int RATE_LSB   = 0;
  localparam int VSWING_LSB = 4;
  localparam int RSVD_LSB   = 9;

  localparam logic [3:0] MSG_CAL_DONE_REQ   = 4'b0001;
  localparam logic [3:0] MSG_CAL_DONE_RESP  = 4'b0010;
  localparam logic [3:0] MSG_PARAM_CFG_REQ  = 4'b0011;
  localparam logic [3:0] MSG_PARAM_CFG_RESP = 4'b0100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUS,
    ST_SEND_REQ,
    ST_WAIT_RESP,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } param_state_t;

  // Reserved bits of the sideband data field always travel as zero.
  function automatic logic [FIELD_W-1:0] pack_param(input logic [RATE_W-1:0]   rate,
                                                    input logic [VSWING_W-1:0] vswing);
    pack_param = {{(FIELD_W - RSVD_LSB){1'b0}}, vswing, rate};
  endfunction

endpackage

// File: rtl/mbinit_param_module_side_if.sv
// Sideband-facing signal bundle of the MBINIT.PARAM initiator; the design
// takes the slave view, the surrounding logic drives through master.
interface mbinit_param_module_side_if;
  import mbinit_param_module_side_pkg::*;

  logic                i_MBINIT_start;
  logic [RATE_W-1:0]   i_local_max_rate;
  logic [VSWING_W-1:0] i_local_vswing;
  logic [3:0]          i_RX_SbMessage;
  logic [FIELD_W-1:0]  i_RX_data_field;
  logic                i_msg_valid;
  logic                i_Busy_SideBand;
  logic                i_falling_edge_busy;
  logic [3:0]          o_TX_SbMessage;
  logic [FIELD_W-1:0]  o_TX_data_field;
  logic                o_ValidOutData_ModuleSide;
  logic                o_MBINIT_PARAM_end;
  logic [RATE_W-1:0]   o_negotiated_rate;
  logic                o_param_error;

  modport slave (
    input  i_MBINIT_start, i_local_max_rate, i_local_vswing, i_RX_SbMessage,
           i_RX_data_field, i_msg_valid, i_Busy_SideBand, i_falling_edge_busy,
    output o_TX_SbMessage, o_TX_data_field, o_ValidOutData_ModuleSide,
           o_MBINIT_PARAM_end, o_negotiated_rate, o_param_error
  );

  modport master (
    output i_MBINIT_start, i_local_max_rate, i_local_vswing, i_RX_SbMessage,
           i_RX_data_field, i_msg_valid, i_Busy_SideBand, i_falling_edge_busy,
    input  o_TX_SbMessage, o_TX_data_field, o_ValidOutData_ModuleSide,
           o_MBINIT_PARAM_end, o_negotiated_rate, o_param_error
  );

endinterface

// File: rtl/mbinit_param_module_side_timeout_counter.sv
// Saturating WAIT_RESP timeout counter; only exists when
// MBINIT_PARAM_TIMEOUT_EN is defined.
`ifdef MBINIT_PARAM_TIMEOUT_EN
module mbinit_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int CNT_W          = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count >= LIMIT);

endmodule
`endif

// File: rtl/mbinit_param_module_side.sv
// MBINIT.PARAM initiator: sends the local PARAM request, checks the partner
// response and gates MBINIT_CAL. Optional timeout: MBINIT_PARAM_TIMEOUT_EN.
module mbinit_param_module_side
  import mbinit_param_module_side_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int CNT_W          = 13
) (
  input logic                        CLK,
  input logic                        rst_n,
  mbinit_param_module_side_if.slave  bus
);

  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_check
    $error("CNT_W is too narrow to hold TIMEOUT_CYCLES");
  end

  param_state_t        state, next_state;
  logic [RATE_W-1:0]   local_rate, rx_rate, send_rate;
  logic [VSWING_W-1:0] local_vswing, rx_vswing, send_vswing;
  logic                entering_send, entering_wait, resp_seen, timed_out;
  logic                unused_rsvd;

  assign unused_rsvd   = ^bus.i_RX_data_field[FIELD_W-1:RSVD_LSB];
  assign resp_seen     = bus.i_msg_valid && (bus.i_RX_SbMessage == MSG_PARAM_CFG_RESP);
  assign entering_send = (next_state == ST_SEND_REQ)  && (state != ST_SEND_REQ);
  assign entering_wait = (next_state == ST_WAIT_RESP) && (state != ST_WAIT_RESP);
  assign send_rate     = entering_send ? bus.i_local_max_rate : local_rate;
  assign send_vswing   = entering_send ? bus.i_local_vswing   : local_vswing;

`ifdef MBINIT_PARAM_TIMEOUT_EN
  mbinit_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk     (CLK),
    .rst_n   (rst_n),
    .clear   (entering_wait),
    .enable  (state == ST_WAIT_RESP),
    .expired (timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  // Dropping i_MBINIT_start aborts from any state, even over a same-cycle response.
  always_comb begin
    next_state = state;
    if (!bus.i_MBINIT_start) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      next_state = ST_WAIT_BUS;
        ST_WAIT_BUS:  if (!bus.i_Busy_SideBand) next_state = ST_SEND_REQ;
        ST_SEND_REQ:  if (bus.i_falling_edge_busy) next_state = ST_WAIT_RESP;
        ST_WAIT_RESP: begin
          if (resp_seen)      next_state = ST_CHECK;
          else if (timed_out) next_state = ST_ERROR;
        end
        ST_CHECK: begin
          if ((rx_rate <= local_rate) && (rx_vswing == local_vswing)) next_state = ST_DONE;
          else                                                        next_state = ST_ERROR;
        end
        ST_DONE:      next_state = ST_DONE;
        ST_ERROR:     next_state = ST_ERROR;
        default:      next_state = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from next_state so they line up with the registered state.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state                         <= ST_IDLE;
      local_rate                    <= '0;
      local_vswing                  <= '0;
      rx_rate                       <= '0;
      rx_vswing                     <= '0;
      bus.o_TX_SbMessage            <= '0;
      bus.o_TX_data_field           <= '0;
      bus.o_ValidOutData_ModuleSide <= 1'b0;
      bus.o_MBINIT_PARAM_end        <= 1'b0;
      bus.o_negotiated_rate         <= '0;
      bus.o_param_error             <= 1'b0;
    end else begin
      state <= next_state;
      if (entering_send) begin
        local_rate            <= bus.i_local_max_rate;
        local_vswing          <= bus.i_local_vswing;
        bus.o_negotiated_rate <= '0;
      end
      if ((state == ST_WAIT_RESP) && (next_state == ST_CHECK)) begin
        rx_rate   <= bus.i_RX_data_field[RATE_LSB +: RATE_W];
        rx_vswing <= bus.i_RX_data_field[VSWING_LSB +: VSWING_W];
      end
      if ((state == ST_CHECK) && (next_state == ST_DONE)) begin
        bus.o_negotiated_rate <= rx_rate;
      end
      bus.o_TX_SbMessage            <= (next_state == ST_SEND_REQ) ? MSG_PARAM_CFG_REQ : 4'b0000;
      bus.o_TX_data_field           <= (next_state == ST_SEND_REQ) ?
                                       pack_param(send_rate, send_vswing) : '0;
      bus.o_ValidOutData_ModuleSide <= (next_state == ST_SEND_REQ);
      bus.o_MBINIT_PARAM_end        <= (next_state == ST_DONE);
      bus.o_param_error             <= (next_state == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_mbinit_param_module_side.sv
// Directed and randomized exchanges against a request/response model of the
// MBINIT.PARAM initiator; the timeout case follows MBINIT_PARAM_TIMEOUT_EN.
module tb_mbinit_param_module_side;
  import mbinit_param_module_side_pkg::*;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] exp_neg_rate = 4'h0;

  always #5 CLK = ~CLK;

  mbinit_param_module_side_if bus ();

  mbinit_param_module_side #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (5)
  ) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_nib(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_bit({tag, "_valid"}, bus.o_ValidOutData_ModuleSide, 1'b0);
    check_bit({tag, "_end"},   bus.o_MBINIT_PARAM_end,        1'b0);
    check_bit({tag, "_err"},   bus.o_param_error,             1'b0);
  endtask

  // Raise start, optionally hold the bus busy, check the request, finish its TX.
  task automatic reach_wait_resp(input logic [3:0] rate, input logic [4:0] vs, input int busy_cyc);
    logic [15:0] exp_field;
    exp_field = {7'b0, vs, rate};
    bus.i_local_max_rate = rate;
    bus.i_local_vswing   = vs;
    bus.i_Busy_SideBand  = (busy_cyc > 0);
    bus.i_MBINIT_start   = 1'b1;
    tick();
    check_bit("wait_bus_valid", bus.o_ValidOutData_ModuleSide, 1'b0);
    for (int i = 0; i < busy_cyc; i++) begin
      bus.i_falling_edge_busy = (i == 1);
      tick();
      check_bit("busy_hold_valid", bus.o_ValidOutData_ModuleSide, 1'b0);
    end
    bus.i_falling_edge_busy = 1'b0;
    bus.i_Busy_SideBand     = 1'b0;
    tick();
    exp_neg_rate = 4'h0;
    check_bit("req_valid", bus.o_ValidOutData_ModuleSide, 1'b1);
    check_nib("req_msg", bus.o_TX_SbMessage, MSG_PARAM_CFG_REQ);
    check_vec("req_field", bus.o_TX_data_field, exp_field);
    check_nib("req_neg_cleared", bus.o_negotiated_rate, exp_neg_rate);
    bus.i_local_max_rate = ~rate;
    bus.i_local_vswing   = ~vs;
    tick();
    check_vec("req_field_held", bus.o_TX_data_field, exp_field);
    bus.i_falling_edge_busy = 1'b1;
    tick();
    bus.i_falling_edge_busy = 1'b0;
    check_bit("resp_wait_valid", bus.o_ValidOutData_ModuleSide, 1'b0);
    check_nib("resp_wait_msg", bus.o_TX_SbMessage, 4'h0);
  endtask

  // Deliver the response and compare the verdict with the acceptance rule.
  task automatic finish_exchange(input logic [3:0] rate, input logic [4:0] vs,
                                 input logic [3:0] rrate, input logic [4:0] rvs, input bit noise);
    logic accept;
    accept = (rrate <= rate) && (rvs == vs);
    bus.i_falling_edge_busy = 1'b1;
    tick();
    bus.i_falling_edge_busy = 1'b0;
    check_quiet("stray_strobe");
    if (noise) begin
      bus.i_msg_valid     = 1'b1;
      bus.i_RX_SbMessage  = ($urandom_range(0, 1) == 0) ? MSG_CAL_DONE_REQ : MSG_CAL_DONE_RESP;
      bus.i_RX_data_field = {7'b0, rvs, rrate};
      tick();
      bus.i_msg_valid = 1'b0;
      check_quiet("noise_ignored");
      tick();
      check_quiet("noise_after");
    end
    bus.i_msg_valid     = 1'b1;
    bus.i_RX_SbMessage  = MSG_PARAM_CFG_RESP;
    bus.i_RX_data_field = {7'($urandom), rvs, rrate};
    tick();
    bus.i_msg_valid = 1'b0;
    check_quiet("check_cycle");
    tick();
    if (accept) exp_neg_rate = rrate;
    check_bit("verdict_end", bus.o_MBINIT_PARAM_end, accept);
    check_bit("verdict_err", bus.o_param_error, !accept);
    check_nib("verdict_neg", bus.o_negotiated_rate, exp_neg_rate);
    tick();
    check_bit("verdict_end_held", bus.o_MBINIT_PARAM_end, accept);
    check_bit("verdict_err_held", bus.o_param_error, !accept);
  endtask

  task automatic apply_stimulus(input logic [3:0] rate, input logic [4:0] vs,
                                input logic [3:0] rrate, input logic [4:0] rvs,
                                input int busy_cyc, input bit noise);
    reach_wait_resp(rate, vs, busy_cyc);
    finish_exchange(rate, vs, rrate, rvs, noise);
    bus.i_MBINIT_start = 1'b0;
    tick();
    check_quiet("abort_idle");
    check_nib("abort_neg_held", bus.o_negotiated_rate, exp_neg_rate);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before the summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] r, rr;
    logic [4:0] v, rv;

    bus.i_MBINIT_start      = 1'b0;
    bus.i_local_max_rate    = '0;
    bus.i_local_vswing      = '0;
    bus.i_RX_SbMessage      = '0;
    bus.i_RX_data_field     = '0;
    bus.i_msg_valid         = 1'b0;
    bus.i_Busy_SideBand     = 1'b0;
    bus.i_falling_edge_busy = 1'b0;

    #12;
    check_quiet("reset");
    check_nib("reset_msg", bus.o_TX_SbMessage, 4'h0);
    check_vec("reset_field", bus.o_TX_data_field, 16'h0000);
    check_nib("reset_neg", bus.o_negotiated_rate, 4'h0);
    rst_n = 1'b1;
    tick();

    $display("[TB] nominal exchange");
    apply_stimulus(4'h5, 5'h0A, 4'h3, 5'h0A, 0, 1'b0);
    $display("[TB] busy bus, rate equal to local max");
    apply_stimulus(4'h5, 5'h0A, 4'h5, 5'h0A, 10, 1'b0);
    $display("[TB] rate above local max");
    apply_stimulus(4'h5, 5'h0A, 4'h7, 5'h0A, 0, 1'b0);
    $display("[TB] vswing mismatch");
    apply_stimulus(4'h5, 5'h0A, 4'h3, 5'h0B, 0, 1'b0);
    $display("[TB] foreign message before response");
    apply_stimulus(4'h5, 5'h0A, 4'h3, 5'h0A, 0, 1'b1);

    $display("[TB] abort coinciding with response, then restart");
    reach_wait_resp(4'h9, 5'h1F, 0);
    bus.i_MBINIT_start  = 1'b0;
    bus.i_msg_valid     = 1'b1;
    bus.i_RX_SbMessage  = MSG_PARAM_CFG_RESP;
    bus.i_RX_data_field = {7'b0, 5'h1F, 4'h2};
    tick();
    bus.i_msg_valid = 1'b0;
    check_quiet("abort_wins");
    tick();
    check_quiet("abort_stays_idle");
    reach_wait_resp(4'hC, 5'h11, 0);
    finish_exchange(4'hC, 5'h11, 4'hC, 5'h11, 1'b0);
    bus.i_MBINIT_start = 1'b0;
    tick();

    $display("[TB] no response");
    reach_wait_resp(4'h4, 5'h04, 0);
    check_bit("to_cycle1_err", bus.o_param_error, 1'b0);
`ifdef MBINIT_PARAM_TIMEOUT_EN
    for (int k = 2; k <= 17; k++) begin
      tick();
      check_bit("to_err", bus.o_param_error, (k == 17));
    end
`else
    for (int k = 2; k <= 40; k++) begin
      tick();
      if (k % 8 == 0) check_bit("no_to_err", bus.o_param_error, 1'b0);
    end
`endif
    bus.i_MBINIT_start = 1'b0;
    tick();
    check_quiet("to_abort");

    $display("[TB] reset during request and after completion");
    bus.i_MBINIT_start = 1'b1;
    tick();
    tick();
    check_bit("pre_reset_valid", bus.o_ValidOutData_ModuleSide, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_bit("async_rst_valid", bus.o_ValidOutData_ModuleSide, 1'b0);
    check_vec("async_rst_field", bus.o_TX_data_field, 16'h0000);
    bus.i_MBINIT_start = 1'b0;
    rst_n = 1'b1;
    tick();
    reach_wait_resp(4'h8, 5'h15, 0);
    finish_exchange(4'h8, 5'h15, 4'h6, 5'h15, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    exp_neg_rate = 4'h0;
    check_bit("async_rst_end", bus.o_MBINIT_PARAM_end, 1'b0);
    check_nib("async_rst_neg", bus.o_negotiated_rate, exp_neg_rate);
    bus.i_MBINIT_start = 1'b0;
    rst_n = 1'b1;
    tick();

    $display("[TB] randomized exchanges");
    for (int n = 0; n < 24; n++) begin
      r  = 4'($urandom);
      v  = 5'($urandom);
      rr = 4'($urandom);
      rv = ($urandom_range(0, 3) == 0) ? 5'($urandom) : v;
      apply_stimulus(r, v, rr, rv, int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
